// File: rtl/function_generator_pkg.sv
// -----------------------------------------------------------------------------
// function_generator_pkg
//   Shared constants for the multi-channel function generator: the waveform
//   mode encodings and the bit positions of the fields in each channel's
//   8-bit control byte.
// -----------------------------------------------------------------------------
package function_generator_pkg;

    // Waveform mode encodings, carried in control[CTRL_MODE_MSB:CTRL_MODE_LSB].
    localparam logic [2:0] MODE_OFF    = 3'b000;
    localparam logic [2:0] MODE_DC     = 3'b001;
    localparam logic [2:0] MODE_RSVD2  = 3'b010;
    localparam logic [2:0] MODE_SQUARE = 3'b011;
    localparam logic [2:0] MODE_TRI    = 3'b100;
    localparam logic [2:0] MODE_SAW    = 3'b101;
    localparam logic [2:0] MODE_RAMPDN = 3'b110;
    localparam logic [2:0] MODE_RSVD7  = 3'b111;

    // Field positions inside one channel's control byte.
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 3;

endpackage

// File: rtl/function_generator_ch.sv
// -----------------------------------------------------------------------------
// function_generator_ch
//   One waveform channel. Detects the rising edge of enable, latches the
//   configuration at that edge, runs a prescaler that paces a phase counter
//   (pos), and decodes pos into a sample according to the latched mode.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   control     in   [0] enable, [3:1] mode, [7:4] ignored
//   prescaler   in   pos advances every prescaler+1 clocks
//   amplitude   in   peak value / ramp terminal
//   period      in   square-wave terminal count
//   duty        in   square-wave high time (pos < duty)
//   sync        in   realign a running channel to phase 0
//   data        out  decoded sample (0 when not running)
//   data_valid  out  channel running
//   wrap        out  one-cycle pulse when pos wraps terminal -> 0
// -----------------------------------------------------------------------------
module function_generator_ch
    import function_generator_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         control,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic [DATA_W-1:0]  amplitude,
    input  logic [DATA_W-1:0]  period,
    input  logic [DATA_W-1:0]  duty,
    input  logic               sync,
    output logic [DATA_W-1:0]  data,
    output logic               data_valid,
    output logic               wrap
);

    localparam logic [DATA_W:0]    POS_ONE  = (DATA_W+1)'(1);
    localparam logic [PRESC_W-1:0] PCNT_ONE = PRESC_W'(1);

    // The upper nibble of the control byte has no function.
    logic ctrl_unused;
    assign ctrl_unused = ^control[7:4];

    // Registered state.
    logic               run_q,     run_d;
    logic               en_prev_q, en_prev_d;
    logic [2:0]         mode_q,    mode_d;
    logic [PRESC_W-1:0] presc_q,   presc_d;
    logic [DATA_W-1:0]  amp_q,     amp_d;
    logic [DATA_W-1:0]  period_q,  period_d;
    logic [DATA_W-1:0]  duty_q,    duty_d;
    logic [PRESC_W-1:0] pcnt_q,    pcnt_d;
    // One bit wider than a sample: the triangle runs up to 2*amp-1.
    logic [DATA_W:0]    pos_q,     pos_d;
    logic               wrap_q,    wrap_d;

    logic               en;
    logic               start;
    logic [DATA_W:0]    term;
    logic [DATA_W:0]    tri_fall;

    assign en    = control[CTRL_EN];
    assign start = en && !en_prev_q;

    // Terminal value of pos for the latched mode.
    always_comb begin
        term = '0;
        unique case (mode_q)
            MODE_SQUARE: term = {1'b0, period_q};
            MODE_TRI:    term = (amp_q == '0) ? '0 : ({amp_q, 1'b0} - POS_ONE);
            MODE_SAW,
            MODE_RAMPDN: term = {1'b0, amp_q};
            default:     term = '0;
        endcase
    end

    // Next-state logic. Priority: enable low, start edge, sync, prescaler tick.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        run_d     = run_q;
        en_prev_d = en;
        mode_d    = mode_q;
        presc_d   = presc_q;
        amp_d     = amp_q;
        period_d  = period_q;
        duty_d    = duty_q;
        pcnt_d    = pcnt_q;
        pos_d     = pos_q;
        wrap_d    = 1'b0;

        if (!en) begin
            run_d  = 1'b0;
            pcnt_d = '0;
            pos_d  = '0;
        end else if (start) begin
            // Configuration is captured only here; later input changes are ignored.
            mode_d   = control[CTRL_MODE_MSB:CTRL_MODE_LSB];
            presc_d  = prescaler;
            amp_d    = amplitude;
            period_d = period;
            duty_d   = duty;
            run_d    = 1'b1;
            pcnt_d   = '0;
            pos_d    = '0;
        end else if (run_q) begin
            if (sync) begin
                pcnt_d = '0;
                pos_d  = '0;
            end else if (pcnt_q == presc_q) begin
                pcnt_d = '0;
                if (pos_q == term) begin
                    pos_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    pos_d = pos_q + POS_ONE;
                end
            end else begin
                pcnt_d = pcnt_q + PCNT_ONE;
            end
        end
    end

    // NOTE: the latched configuration is reset along with the counters so the reset state is fully defined.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks keep every flop sampling pre-edge values.
        if (rst) begin
            run_q     <= 1'b0;
            en_prev_q <= 1'b0;
            mode_q    <= MODE_OFF;
            presc_q   <= '0;
            amp_q     <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            pcnt_q    <= '0;
            pos_q     <= '0;
            wrap_q    <= 1'b0;
        end else begin
            run_q     <= run_d;
            en_prev_q <= en_prev_d;
            mode_q    <= mode_d;
            presc_q   <= presc_d;
            amp_q     <= amp_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            pcnt_q    <= pcnt_d;
            pos_q     <= pos_d;
            wrap_q    <= wrap_d;
        end
    end

    // Falling half of the triangle: 2*amp - pos, only used when pos > amp.
    assign tri_fall = {amp_q, 1'b0} - pos_q;

    // Sample decode from registered pos and latched configuration.
    always_comb begin
        data = '0;
        if (run_q) begin
            unique case (mode_q)
                MODE_DC:     data = amp_q;
                MODE_SQUARE: data = (pos_q < {1'b0, duty_q}) ? amp_q : '0;
                MODE_TRI:    data = (pos_q <= {1'b0, amp_q}) ? pos_q[DATA_W-1:0]
                                                             : tri_fall[DATA_W-1:0];
                MODE_SAW:    data = pos_q[DATA_W-1:0];
                MODE_RAMPDN: data = amp_q - pos_q[DATA_W-1:0];
                default:     data = '0;
            endcase
        end
    end

    assign data_valid = run_q;
    assign wrap       = wrap_q;

endmodule

// File: rtl/function_generator_mc.sv
// -----------------------------------------------------------------------------
// function_generator_mc
//   Multi-channel waveform generator. Instantiates CHANNELS independent
//   function_generator_ch channels, slices the flat per-channel input and
//   output vectors (channel 0 in the LSBs) and fans the shared sync out.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   control     in   CHANNELS x 8       [0] enable, [3:1] mode, [7:4] ignored
//   prescaler   in   CHANNELS x PRESC_W tick every prescaler+1 clocks
//   amplitude   in   CHANNELS x DATA_W  peak value / ramp terminal
//   period      in   CHANNELS x DATA_W  square terminal count
//   duty        in   CHANNELS x DATA_W  square high while pos < duty
//   sync        in   realign all running channels to phase 0
//   data        out  CHANNELS x DATA_W  per-channel sample
//   data_valid  out  CHANNELS           channel running
//   wrap        out  CHANNELS           one-cycle wrap pulse
// -----------------------------------------------------------------------------
module function_generator_mc
    import function_generator_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int PRESC_W  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CHANNELS*8-1:0]       control,
    input  logic [CHANNELS*PRESC_W-1:0] prescaler,
    input  logic [CHANNELS*DATA_W-1:0]  amplitude,
    input  logic [CHANNELS*DATA_W-1:0]  period,
    input  logic [CHANNELS*DATA_W-1:0]  duty,
    input  logic                        sync,
    output logic [CHANNELS*DATA_W-1:0]  data,
    output logic [CHANNELS-1:0]         data_valid,
    output logic [CHANNELS-1:0]         wrap
);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        function_generator_ch #(
            .DATA_W  (DATA_W),
            .PRESC_W (PRESC_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .control    (control[ch*8 +: 8]),
            .prescaler  (prescaler[ch*PRESC_W +: PRESC_W]),
            .amplitude  (amplitude[ch*DATA_W +: DATA_W]),
            .period     (period[ch*DATA_W +: DATA_W]),
            .duty       (duty[ch*DATA_W +: DATA_W]),
            .sync       (sync),
            .data       (data[ch*DATA_W +: DATA_W]),
            .data_valid (data_valid[ch]),
            .wrap       (wrap[ch])
        );
    end

endmodule

// File: tb/tb_function_generator_mc.sv
// -----------------------------------------------------------------------------
// tb_function_generator_mc
//   Directed bench for the two-channel generator. Inputs change just after the
//   falling edge; outputs are sampled on the falling edge, half a cycle after
//   the rising edge that updated them.
// -----------------------------------------------------------------------------
module tb_function_generator_mc;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int PW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [CH*8-1:0]   control;
    logic [CH*PW-1:0]  prescaler;
    logic [CH*DW-1:0]  amplitude;
    logic [CH*DW-1:0]  period;
    logic [CH*DW-1:0]  duty;
    logic              sync;
    logic [CH*DW-1:0]  data;
    logic [CH-1:0]     data_valid;
    logic [CH-1:0]     wrap;

    int n_cmp = 0;
    int n_bad = 0;

    function_generator_mc #(
        .CHANNELS (CH),
        .DATA_W   (DW),
        .PRESC_W  (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .control    (control),
        .prescaler  (prescaler),
        .amplitude  (amplitude),
        .period     (period),
        .duty       (duty),
        .sync       (sync),
        .data       (data),
        .data_valid (data_valid),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input int ch, input logic en, input logic [2:0] mode,
                       input logic [15:0] presc, input logic [15:0] amp,
                       input logic [15:0] per, input logic [15:0] dty);
        control[ch*8 +: 8]     = {4'b0000, mode, en};
        prescaler[ch*PW +: PW] = presc;
        amplitude[ch*DW +: DW] = amp;
        period[ch*DW +: DW]    = per;
        duty[ch*DW +: DW]      = dty;
    endtask

    task automatic set_en(input int ch, input logic en);
        control[ch*8] = en;
    endtask

    function automatic logic [15:0] dat(input int ch);
        return data[ch*DW +: DW];
    endfunction

    // Checks data/valid/wrap of one channel in one go.
    task automatic check_ch(input string tag, input int ch, input logic [15:0] exp_d,
                            input logic exp_v, input logic exp_w);
        check({tag, " data"},  32'(dat(ch)),          32'(exp_d));
        check({tag, " valid"}, 32'(data_valid[ch]),   32'(exp_v));
        check({tag, " wrap"},  32'(wrap[ch]),         32'(exp_w));
    endtask

    logic [15:0] tri_exp [16] = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0, 1, 1, 2, 2, 1, 1};
    logic [15:0] sq_exp  [10] = '{16'hFF, 16'hFF, 0, 0, 0, 16'hFF, 16'hFF, 0, 0, 0};
    logic [15:0] rd_exp  [6]  = '{3, 2, 1, 0, 3, 2};

    initial begin
        rst       = 1'b1;
        control   = '0;
        prescaler = '0;
        amplitude = '0;
        period    = '0;
        duty      = '0;
        sync      = 1'b0;
        step();
        step();

        // Reset state.
        check("rst data",  32'(data),       32'h0);
        check("rst valid", 32'(data_valid), 32'h0);
        check("rst wrap",  32'(wrap),       32'h0);
        rst = 1'b0;
        step();

        // 1: sawtooth amp=3 presc=0 -> 0,1,2,3,0,... wrap with each return to 0.
        cfg(0, 1'b1, 3'b101, 16'd0, 16'd3, 16'd0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check_ch($sformatf("saw[%0d]", i), 0, 16'(i % 4), 1'b1, (i > 0) && (i % 4 == 0));
        end
        check("saw ch1 idle", 32'(data_valid[1]), 32'h0);
        set_en(0, 1'b0);
        step();
        check_ch("saw off", 0, 16'd0, 1'b0, 1'b0);

        // 2: triangle amp=2 presc=1 -> 8-clock period, wrap once at its start.
        cfg(0, 1'b1, 3'b100, 16'd1, 16'd2, 16'd0, 16'd0);
        for (int i = 0; i < 16; i++) begin
            step();
            check_ch($sformatf("tri[%0d]", i), 0, tri_exp[i], 1'b1, i == 8);
        end
        set_en(0, 1'b0);
        step();

        // 3: square period=4 duty=2 amp=FF -> FF,FF,0,0,0 repeating.
        cfg(0, 1'b1, 3'b011, 16'd0, 16'h00FF, 16'd4, 16'd2);
        for (int i = 0; i < 10; i++) begin
            step();
            check_ch($sformatf("sq[%0d]", i), 0, sq_exp[i], 1'b1, i == 5);
        end
        set_en(0, 1'b0);
        step();
        // duty=0 -> constant 0.
        cfg(0, 1'b1, 3'b011, 16'd0, 16'h00FF, 16'd4, 16'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_ch($sformatf("sq d0[%0d]", i), 0, 16'd0, 1'b1, i == 5);
        end
        set_en(0, 1'b0);
        step();
        // duty>period -> constant amp.
        cfg(0, 1'b1, 3'b011, 16'd0, 16'h00FF, 16'd4, 16'd9);
        for (int i = 0; i < 6; i++) begin
            step();
            check_ch($sformatf("sq dbig[%0d]", i), 0, 16'h00FF, 1'b1, i == 5);
        end
        set_en(0, 1'b0);
        step();

        // 4: sync realigns both channels; sync beats the pending ch0 wrap.
        cfg(0, 1'b1, 3'b101, 16'd0, 16'd7, 16'd0, 16'd0);
        cfg(1, 1'b1, 3'b101, 16'd3, 16'd7, 16'd0, 16'd0);
        step();
        for (int i = 0; i < 7; i++) step();
        check_ch("pre-sync ch0", 0, 16'd7, 1'b1, 1'b0);
        check_ch("pre-sync ch1", 1, 16'd1, 1'b1, 1'b0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_ch("sync ch0", 0, 16'd0, 1'b1, 1'b0);
        check_ch("sync ch1", 1, 16'd0, 1'b1, 1'b0);
        step();
        check("post-sync ch0", 32'(dat(0)), 32'd1);
        check("post-sync ch1", 32'(dat(1)), 32'd0);
        for (int i = 0; i < 3; i++) step();
        check("sync+4 ch0", 32'(dat(0)), 32'd4);
        check("sync+4 ch1", 32'(dat(1)), 32'd1);
        set_en(0, 1'b0);
        set_en(1, 1'b0);
        step();
        // sync on idle channels has no effect.
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("idle sync valid", 32'(data_valid), 32'h0);
        check("idle sync data",  32'(data),       32'h0);

        // 5: config changes ignored while running; re-enable picks them up.
        cfg(0, 1'b1, 3'b101, 16'd0, 16'd3, 16'd0, 16'd0);
        step();
        step();
        amplitude[DW-1:0] = 16'd5;
        step();
        step();
        check("hold amp 3", 32'(dat(0)), 32'd3);
        step();
        check_ch("hold wrap", 0, 16'd0, 1'b1, 1'b1);
        set_en(0, 1'b0);
        step();
        check_ch("drop en", 0, 16'd0, 1'b0, 1'b0);
        set_en(0, 1'b1);
        step();
        check_ch("restart", 0, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        check("amp5 top", 32'(dat(0)), 32'd5);
        step();
        check_ch("amp5 wrap", 0, 16'd0, 1'b1, 1'b1);
        set_en(0, 1'b0);
        step();
        cfg(0, 1'b1, 3'b111, 16'd0, 16'd5, 16'd0, 16'd0);
        step();
        check_ch("mode7", 0, 16'd0, 1'b1, 1'b0);
        step();
        check_ch("mode7 T=0 wrap", 0, 16'd0, 1'b1, 1'b1);
        set_en(0, 1'b0);
        step();

        // DC and ramp-down.
        cfg(0, 1'b1, 3'b001, 16'd0, 16'h1234, 16'd0, 16'd0);
        step();
        check_ch("dc", 0, 16'h1234, 1'b1, 1'b0);
        set_en(0, 1'b0);
        step();
        cfg(0, 1'b1, 3'b110, 16'd0, 16'd3, 16'd0, 16'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check_ch($sformatf("rampdn[%0d]", i), 0, rd_exp[i], 1'b1, i == 4);
        end

        // 6: reset mid-run with enable held -> restart from 0 after reset.
        cfg(0, 1'b1, 3'b101, 16'd0, 16'd3, 16'd0, 16'd0);
        set_en(0, 1'b0);
        step();
        set_en(0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        check("pre-rst", 32'(dat(0)), 32'd3);
        rst = 1'b1;
        step();
        check_ch("rst mid", 0, 16'd0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_ch("rst restart", 0, 16'd0, 1'b1, 1'b0);
        step();
        check_ch("rst restart+1", 0, 16'd1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
